// File: rtl/fetch_if_id_if.sv
// Fetch-side bundle: imem read port, decode-facing IF/ID outputs,
// and the hazard/redirect controls that steer fetch.
interface fetch_if_id_if #(
  parameter int PC_W = 32
);
  logic            pick_bubble;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;

  modport master (
    input  pick_bubble,
    input  redirect,
    input  redirect_pc,
    input  imem_rdata,
    output imem_en,
    output imem_addr,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid
  );

  modport slave (
    output pick_bubble,
    output redirect,
    output redirect_pc,
    output imem_rdata,
    input  imem_en,
    input  imem_addr,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid
  );
endinterface

// File: rtl/fetch_if_id.sv
// Fetch stage + IF/ID register with 1-entry skid for the sync imem.
// Optional stall counter port enabled by FETCH_PERF_CNT_EN.
module fetch_if_id #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  fetch_if_id_if.master    bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic [PC_W-1:0] r_pc;
  logic            r_infl;
  logic [PC_W-1:0] r_infl_pc;
  logic            r_skid_v;
  logic [PC_W-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;
  logic            r_id_v;
  logic [PC_W-1:0] r_id_pc;
  logic [31:0]     r_id_instr;

  logic            w_en;
  logic            w_adv;
  logic            w_hold;
  logic [PC_W-1:0] w_tgt;

  assign w_adv  = bus.pick_bubble & ~bus.redirect;
  assign w_hold = ~bus.pick_bubble & ~bus.redirect;
  assign w_en   = ~rst & w_adv;
  assign w_tgt  = {bus.redirect_pc[PC_W-1:2], 2'b00};

  assign bus.imem_en     = w_en;
  assign bus.imem_addr   = r_pc;
  assign bus.if_id_pc    = r_id_pc;
  assign bus.if_id_instr = r_id_instr;
  assign bus.if_id_valid = r_id_v;

  // PC, in-flight tracking, skid capture and IF/ID load
  always_ff @(posedge clk) begin
    r_infl_pc <= r_pc;
    if (rst) begin
      r_pc         <= RESET_PC;
      r_infl       <= 1'b0;
      r_skid_v     <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_id_v       <= 1'b0;
      r_id_pc      <= '0;
      r_id_instr   <= NOP_INSTR;
    end else begin
      r_infl <= w_en;
      if (bus.redirect) begin
        r_pc       <= w_tgt;
        r_infl     <= 1'b0;
        r_skid_v   <= 1'b0;
        r_id_v     <= 1'b0;
        r_id_instr <= NOP_INSTR;
      end else if (w_adv) begin
        r_pc <= r_pc + PC_W'(4);
        if (r_skid_v) begin
          r_id_v     <= 1'b1;
          r_id_pc    <= r_skid_pc;
          r_id_instr <= r_skid_instr;
          r_skid_v   <= 1'b0;
        end else if (r_infl) begin
          r_id_v     <= 1'b1;
          r_id_pc    <= r_infl_pc;
          r_id_instr <= bus.imem_rdata;
        end else begin
          r_id_v     <= 1'b0;
          r_id_instr <= NOP_INSTR;
        end
      end else if (w_hold && r_infl) begin
        // imem data is only present this cycle; park it
        r_skid_v     <= 1'b1;
        r_skid_pc    <= r_infl_pc;
        r_skid_instr <= bus.imem_rdata;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall;

  // saturating count of hold cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_hold && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: vector table plus scoreboard of fetched PCs.
// Define FETCH_PERF_CNT_EN to also check the stall counter.
module tb_fetch_if_id;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if_id_if #(.PC_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_if_id #(.PC_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= pat(bus.imem_addr);

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  bit          m_adv;
  logic [31:0] m_exp;

  always @(posedge clk) begin
    m_adv = bus.pick_bubble & ~bus.redirect & ~rst;
    #2;
    if (m_adv && bus.if_id_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_extra: got pc %h expected none",
                 bus.if_id_pc);
      end else begin
        m_exp = sb.pop_front();
        chk("sb_pc", bus.if_id_pc, m_exp);
        chk("sb_instr", bus.if_id_instr, pat(m_exp));
      end
    end
  end

  task automatic step(input bit r, input bit pb, input bit rd,
                      input logic [31:0] rpc, input bit een,
                      input bit ev, input logic [31:0] epc,
                      input string nm);
    @(negedge clk);
    rst             = r;
    bus.pick_bubble = pb;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    if (!r && pb && !rd && ev) sb.push_back(epc);
    #1;
    chk({nm, "_en"}, 32'(bus.imem_en), 32'(een));
    @(posedge clk);
    #1;
    chk({nm, "_v"}, 32'(bus.if_id_valid), 32'(ev));
    if (ev) chk({nm, "_pc"}, bus.if_id_pc, epc);
    else    chk({nm, "_nop"}, bus.if_id_instr, NOP);
  endtask

  typedef struct packed {
    bit          pb;
    bit          rd;
    logic [31:0] rpc;
    bit          een;
    bit          ev;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104};
    tbl[14] = '{1'b0, 1'b1, 32'h203, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
    tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204};

    bus.pick_bubble = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata  = '0;
    rst             = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_v", 32'(bus.if_id_valid), 32'd0);
    chk("rst_instr", bus.if_id_instr, NOP);
    chk("rst_pc", bus.if_id_pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_cnt", stall_cnt, 32'h0);
`endif

    foreach (tbl[i])
      step(1'b0, tbl[i].pb, tbl[i].rd, tbl[i].rpc, tbl[i].een,
           tbl[i].ev, tbl[i].epc, $sformatf("tbl%0d", i));

    step(0, 0, 0, 32'h0, 0, 1, 32'h204, "t5_hold");
    step(1, 0, 0, 32'h0, 0, 0, 32'h0, "t5_rst");
    chk("t5_pc", bus.if_id_pc, 32'h0);
    chk("t5_addr", bus.imem_addr, 32'h0);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0, "t5_r1");
    step(0, 1, 0, 32'h0, 1, 1, 32'h0, "t5_r2");
    step(0, 1, 0, 32'h0, 1, 1, 32'h4, "t5_r3");

    step(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, "wr_rd");
    step(0, 1, 0, 32'h0, 1, 0, 32'h0, "wr_b");
    step(0, 1, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, "wr_top");
    step(0, 1, 0, 32'h0, 1, 1, 32'h0, "wr_zero");
    chk("wr_addr", bus.imem_addr, 32'h8);

    step(1, 0, 0, 32'h0, 0, 0, 32'h0, "pc_rst");
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_rst", stall_cnt, 32'h0);
`endif
    for (int k = 0; k < 4; k++)
      step(0, 0, 0, 32'h0, 0, 0, 32'h0, "pc_st");
    step(0, 0, 1, 32'h40, 0, 0, 32'h0, "pc_rd");
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_4", stall_cnt, 32'd4);
`endif
    chk("pc_tgt", bus.imem_addr, 32'h40);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
